// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared RV32 core constants, opcodes and fetch entry type.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] CUSTOM0 = 7'b0001011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO with flush, used to buffer {pc, instr}.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && full_o && !do_pop));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : RV32 fetch front end: PC, credit-limited imem requests,
//                instruction FIFO and redirect flush. Optional macro
//                FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned halt.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int            CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          run_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   inflight;
    logic          fifo_empty, halt, req_fire, push, pop;
    logic [31:0]   redirect_tgt;
    fetch_entry_t  push_entry, head_entry;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) misaligned_d = (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) misaligned_q <= 1'b0;
        else       misaligned_q <= misaligned_d;
    end

    assign halt             = misaligned_q;
    assign fetch_misaligned = misaligned_q;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign halt                 = 1'b0;
`endif

    // Credits cover both in-flight requests and buffered words, so the FIFO cannot overflow.
    assign inflight       = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = run_q && !halt && (inflight < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop            = instr_valid && instr_ready && !redirect_valid;
    assign push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !imem_rsp_valid)      outstanding_d = outstanding_q + CNT_ONE;
        else if (!req_fire && imem_rsp_valid) outstanding_d = outstanding_q - CNT_ONE;

        drop_d = drop_q;
        if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_ONE;

        fetch_pc_d = fetch_pc_q;
        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;

        // Responses arrive in order, so the PC of the next kept word just counts up.
        rsp_pc_d = rsp_pc_q;
        if (push) rsp_pc_d = rsp_pc_q + 32'd4;

        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            drop_d     = outstanding_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            run_q         <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  ()
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : head_entry.instr;
    assign instr_pc    = fifo_empty ? RESET_PC  : head_entry.pc;
    assign instr_pc4   = pc_plus4(instr_pc);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit with imem and
//                decode models plus a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc, instr_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    instr_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc4      (instr_pc4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: imem pending requests, delivered-word queue, drop budget.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] mq[$];
    int          drop_m = 0;
    int          cyc = 0;
    logic [31:0] mpc = RESET_PC;
    bit          started = 0;
    bit          halted_m = 0;

    bit          s_rv, s_iv, s_mis;
    logic [31:0] s_ra, s_in, s_pc, s_pc4;
    bit          e_rv, e_iv;
    logic [31:0] e_ra, e_pc;
    bit          fired, popped;
    logic [31:0] popped_pc, popped_in, popped_pc4;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_req_ready = 0; imem_rsp_valid = 0; redirect_valid = 0; instr_ready = 0;
        pend_addr.delete(); pend_due.delete(); mq.delete();
        drop_m = 0; mpc = RESET_PC; started = 0; halted_m = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic cycle(input bit rdy, input bit iready, input bit redir,
                         input logic [31:0] tgt, input int lat);
        bit          had_rsp;
        logic [31:0] ra;
        @(negedge clk);
        e_rv = started && !halted_m && ((pend_addr.size() + mq.size()) < BUF_DEPTH);
        e_ra = mpc;
        e_iv = (mq.size() != 0);
        e_pc = e_iv ? mq[0] : RESET_PC;
        had_rsp = 0; ra = '0;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            had_rsp = 1;
            ra = pend_addr.pop_front();
            void'(pend_due.pop_front());
        end
        imem_rsp_valid = had_rsp;
        imem_rsp_data  = had_rsp ? word_of(ra) : $urandom;
        imem_req_ready = rdy;
        instr_ready    = iready;
        redirect_valid = redir;
        redirect_pc    = tgt;
        #1;
        s_rv = imem_req_valid; s_ra = imem_req_addr; s_iv = instr_valid;
        s_in = instr; s_pc = instr_pc; s_pc4 = instr_pc4;
`ifdef FETCH_MISALIGN_TRAP_EN
        s_mis = fetch_misaligned;
`else
        s_mis = 0;
`endif
        fired  = s_rv && rdy;
        popped = s_iv && iready && !redir;
        popped_pc = s_pc; popped_in = s_in; popped_pc4 = s_pc4;
        if (fired) begin
            pend_addr.push_back(s_ra);
            pend_due.push_back(cyc + lat);
            mpc = mpc + 32'd4;
        end
        if (popped && mq.size() != 0) void'(mq.pop_front());
        if (had_rsp) begin
            if (drop_m > 0) drop_m--;
            else            mq.push_back(ra);
        end
        if (redir) begin
            mq.delete();
            drop_m = pend_addr.size();
            mpc = {tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            halted_m = (tgt[1:0] != 2'b00);
`endif
        end
        @(posedge clk);
        cyc++;
        started = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b want 0", imem_req_valid); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid got %b want 0", instr_valid); else n_pass++;
        n_checks++; if (instr !== 32'h0000_0013) $display("FAIL rst_instr got %h want 00000013", instr); else n_pass++;
        n_checks++; if (instr_pc !== RESET_PC) $display("FAIL rst_instr_pc got %h want %h", instr_pc, RESET_PC); else n_pass++;
        n_checks++; if (instr_pc4 !== RESET_PC + 32'd4) $display("FAIL rst_instr_pc4 got %h want %h", instr_pc4, RESET_PC + 32'd4); else n_pass++;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (fetch_misaligned !== 1'b0) $display("FAIL rst_misaligned got %b want 0", fetch_misaligned); else n_pass++;
`endif
        apply_reset();
        cycle(1, 1, 0, '0, 1);
        n_checks++; if (s_rv !== 1'b0) $display("FAIL first_cycle_req got %b want 0", s_rv); else n_pass++;
        cycle(1, 1, 0, '0, 1);
        n_checks++; if (s_rv !== 1'b1 || s_ra !== RESET_PC) $display("FAIL first_req got v=%b a=%h want v=1 a=%h", s_rv, s_ra, RESET_PC); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] next_pc, hold_pc;
        bit          hold_valid;
        int          delivered;
        apply_reset();
        next_pc = RESET_PC; hold_pc = '0; hold_valid = 0; delivered = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, !(i >= 10 && i < 13), 0, '0, 1);
            if (i == 10) begin hold_valid = s_iv; hold_pc = s_pc; end
            if ((i == 11 || i == 12) && hold_valid) begin
                n_checks++; if (s_iv !== 1'b1 || s_pc !== hold_pc) $display("FAIL stall_stable got v=%b pc=%h want v=1 pc=%h", s_iv, s_pc, hold_pc); else n_pass++;
            end
            if (popped) begin
                n_checks++;
                if (popped_pc !== next_pc || popped_in !== word_of(next_pc) || popped_pc4 !== next_pc + 32'd4)
                    $display("FAIL stream_order got pc=%h in=%h pc4=%h want pc=%h", popped_pc, popped_in, popped_pc4, next_pc);
                else n_pass++;
                next_pc = next_pc + 32'd4; delivered++;
            end
        end
        n_checks++; if (delivered < 12) $display("FAIL stream_count got %0d want >=12", delivered); else n_pass++;
    endtask

    task automatic test_fill();
        int nfire;
        apply_reset();
        nfire = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, '0, 1);
            if (fired) nfire++;
        end
        n_checks++; if (nfire != 2) $display("FAIL fill_requests got %0d want 2", nfire); else n_pass++;
        n_checks++; if (s_rv !== 1'b0) $display("FAIL fill_req_low got %b want 0", s_rv); else n_pass++;
        n_checks++; if (s_iv !== 1'b1 || s_pc !== RESET_PC) $display("FAIL fill_head got v=%b pc=%h want v=1 pc=%h", s_iv, s_pc, RESET_PC); else n_pass++;
        cycle(1, 1, 0, '0, 1);
        cycle(1, 0, 0, '0, 1);
        n_checks++; if (s_rv !== 1'b1) $display("FAIL fill_req_after_pop got %b want 1", s_rv); else n_pass++;
    endtask

    task automatic wait_pop(input string name, input logic [31:0] want_pc);
        bit got;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle(1, 1, 0, '0, 1);
            got = popped;
        end
        n_checks++;
        if (!got) $display("FAIL %s timeout got no instr want pc=%h", name, want_pc);
        else if (popped_pc !== want_pc || popped_in !== word_of(want_pc))
            $display("FAIL %s got pc=%h in=%h want pc=%h in=%h", name, popped_pc, popped_in, want_pc, word_of(want_pc));
        else n_pass++;
    endtask

    task automatic test_redirect();
        apply_reset();
        repeat (3) cycle(1, 0, 0, '0, 8);
        n_checks++; if (pend_addr.size() != 2) $display("FAIL redir_outstanding got %0d want 2", pend_addr.size()); else n_pass++;
        cycle(0, 1, 1, 32'h0000_0100, 8);
        wait_pop("redir_first", 32'h0000_0100);
    endtask

    task automatic test_collide();
        apply_reset();
        repeat (3) cycle(1, 0, 0, '0, 1);
        cycle(1, 1, 1, 32'h0000_0300, 1);
        n_checks++; if (s_iv !== 1'b1 || imem_rsp_valid !== 1'b1) $display("FAIL collide_setup got v=%b rsp=%b want 1 1", s_iv, imem_rsp_valid); else n_pass++;
        cycle(1, 1, 1, 32'h0000_0400, 1);
        n_checks++; if (s_iv !== 1'b0) $display("FAIL collide_flush got v=%b want 0", s_iv); else n_pass++;
        n_checks++; if (s_rv !== 1'b1 || s_ra !== 32'h0000_0300) $display("FAIL collide_accept got v=%b a=%h want v=1 a=00000300", s_rv, s_ra); else n_pass++;
        wait_pop("collide_first", 32'h0000_0400);
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        cycle(1, 1, 1, 32'hFFFF_FFF8, 1);
        want = 32'hFFFF_FFF8;
        for (int j = 0; j < 3; j++) begin
            wait_pop("wrap_pc", want);
            n_checks++; if (popped_pc4 !== want + 32'd4) $display("FAIL wrap_pc4 got %h want %h", popped_pc4, want + 32'd4); else n_pass++;
            want = want + 32'd4;
        end
    endtask

    task automatic test_misalign();
        cycle(1, 1, 1, 32'h0000_0102, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int j = 0; j < 6; j++) begin
            cycle(1, 1, 0, '0, 1);
            n_checks++; if (s_rv !== 1'b0 || s_mis !== 1'b1) $display("FAIL misalign_halt got req=%b mis=%b want 0 1", s_rv, s_mis); else n_pass++;
        end
        cycle(1, 1, 1, 32'h0000_0200, 1);
        wait_pop("misalign_clear", 32'h0000_0200);
        n_checks++; if (s_mis !== 1'b0) $display("FAIL misalign_cleared got %b want 0", s_mis); else n_pass++;
`else
        wait_pop("misalign_forced", 32'h0000_0100);
`endif
    endtask

    task automatic test_random();
        bit          redir;
        logic [31:0] tgt;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            redir = ($urandom_range(0, 19) == 0);
            tgt   = $urandom & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, redir, tgt, $urandom_range(1, 4));
            n_checks++; if (s_rv !== e_rv) $display("FAIL rnd_req_valid cyc=%0d got %b want %b", cyc, s_rv, e_rv); else n_pass++;
            if (e_rv) begin
                n_checks++; if (s_ra !== e_ra) $display("FAIL rnd_req_addr cyc=%0d got %h want %h", cyc, s_ra, e_ra); else n_pass++;
            end
            n_checks++; if (s_iv !== e_iv) $display("FAIL rnd_instr_valid cyc=%0d got %b want %b", cyc, s_iv, e_iv); else n_pass++;
            if (e_iv) begin
                n_checks++;
                if (s_pc !== e_pc || s_in !== word_of(e_pc) || s_pc4 !== e_pc + 32'd4)
                    $display("FAIL rnd_head cyc=%0d got pc=%h in=%h pc4=%h want pc=%h", cyc, s_pc, s_in, s_pc4, e_pc);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect();
        test_collide();
        test_wrap();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
